// File: rtl/gray_mem_arbiter.sv
// rtl/gray_mem_arbiter.sv - two-requester round-robin gray-image read port arbiter with burst lock
// Optional statistics counters: define GRAY_ARB_STAT_EN.
module gray_mem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 9,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        rq_req,
  input  logic [1:0]        rq_lock,
  input  logic [ADDR_W-1:0] rq_addr0,
  input  logic [ADDR_W-1:0] rq_addr1,
  output logic [1:0]        rq_gnt,
  output logic [1:0]        rq_rvalid,
  output logic [DATA_W-1:0] rq_rdata,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data
`ifdef GRAY_ARB_STAT_EN
  ,
  output logic [15:0]       stat_xfer0,
  output logic [15:0]       stat_xfer1,
  output logic [15:0]       stat_wait
`endif
);

  localparam logic [1:0] ST_WAIT_RDY = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_OWN      = 2'd2;
  localparam logic [CNT_W-1:0] CAP   = CNT_W'(MAX_BURST);

  logic [1:0]       state;
  logic             owner;
  logic             last_owner;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tag;
  logic             tag_vld;
  logic             xfer;
  logic             own_req;
  logic             own_lock;
  logic             other_req;
  logic             winner;
  logic             release_own;

  always_comb begin
    xfer      = |(rq_req & rq_gnt);
    own_req   = rq_req[owner];
    own_lock  = rq_lock[owner];
    other_req = rq_req[~owner];
    cnt_nxt   = burst_cnt;
    if (xfer && (burst_cnt < CAP))
      cnt_nxt = burst_cnt + CNT_W'(1);
    // A tie goes to whoever did not hold the port last; otherwise the sole requester wins.
    if (rq_req == 2'b11)
      winner = ~last_owner;
    else
      winner = rq_req[1];
    release_own = (!own_req && !own_lock) || (other_req && (cnt_nxt >= CAP));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_WAIT_RDY;
      rq_gnt     <= 2'b00;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      gray_req   <= 1'b0;
      gray_addr  <= '0;
      tag        <= 1'b0;
      tag_vld    <= 1'b0;
    end else begin
      gray_req <= xfer;
      tag_vld  <= xfer;
      if (xfer) begin
        gray_addr <= owner ? rq_addr1 : rq_addr0;
        tag       <= owner;
      end
      case (state)
        ST_WAIT_RDY: begin
          if (gray_ready)
            state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!gray_ready) begin
            state <= ST_WAIT_RDY;
          end else if (|rq_req) begin
            state      <= ST_OWN;
            owner      <= winner;
            last_owner <= winner;
            burst_cnt  <= '0;
            rq_gnt     <= winner ? 2'b10 : 2'b01;
          end
        end
        ST_OWN: begin
          burst_cnt <= cnt_nxt;
          if (!gray_ready) begin
            state  <= ST_WAIT_RDY;
            rq_gnt <= 2'b00;
          end else if (release_own) begin
            state  <= ST_IDLE;
            rq_gnt <= 2'b00;
          end
        end
        default: begin
          state  <= ST_WAIT_RDY;
          rq_gnt <= 2'b00;
        end
      endcase
    end
  end

  // Read data returns one cycle after the transfer, steered by the registered tag.
  assign rq_rvalid = {tag_vld & tag, tag_vld & ~tag};
  assign rq_rdata  = gray_data;

`ifdef GRAY_ARB_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_xfer0 <= '0;
      stat_xfer1 <= '0;
      stat_wait  <= '0;
    end else begin
      if (rq_req[0] && rq_gnt[0] && (stat_xfer0 != 16'hFFFF))
        stat_xfer0 <= stat_xfer0 + 16'd1;
      if (rq_req[1] && rq_gnt[1] && (stat_xfer1 != 16'hFFFF))
        stat_xfer1 <= stat_xfer1 + 16'd1;
      if ((|(rq_req & ~rq_gnt)) && (stat_wait != 16'hFFFF))
        stat_wait <= stat_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// tb/tb_gray_mem_arbiter.sv - scoreboard bench for gray_mem_arbiter against a behavioural model
module tb_gray_mem_arbiter;

  localparam int MAXB = 9;

  logic        clk;
  logic        reset;
  logic [1:0]  rq_req;
  logic [1:0]  rq_lock;
  logic [13:0] rq_addr0;
  logic [13:0] rq_addr1;
  logic [1:0]  rq_gnt;
  logic [1:0]  rq_rvalid;
  logic [7:0]  rq_rdata;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
`ifdef GRAY_ARB_STAT_EN
  logic [15:0] stat_xfer0;
  logic [15:0] stat_xfer1;
  logic [15:0] stat_wait;
`endif

  gray_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .rq_req     (rq_req),
    .rq_lock    (rq_lock),
    .rq_addr0   (rq_addr0),
    .rq_addr1   (rq_addr1),
    .rq_gnt     (rq_gnt),
    .rq_rvalid  (rq_rvalid),
    .rq_rdata   (rq_rdata),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data)
`ifdef GRAY_ARB_STAT_EN
    ,
    .stat_xfer0 (stat_xfer0),
    .stat_xfer1 (stat_xfer1),
    .stat_wait  (stat_wait)
`endif
  );

  function automatic logic [7:0] pix(input logic [13:0] a);
    logic [13:0] t;
    t = a * 14'd29 + (a >> 7);
    return t[7:0];
  endfunction

  assign gray_data = pix(gray_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int who; logic [13:0] addr; } rsp_t;
  typedef struct { int due; logic [1:0] g; } gnt_t;
  rsp_t rsp_q[$];
  gnt_t gnt_q[$];

  int  vectors = 0;
  int  errs = 0;
  bit  mon_en = 0;

  // Reference model: who holds the port, whether we wait for memory, burst length so far.
  int m_hold;
  int m_last;
  int m_cnt;
  bit m_blocked;
  int last_xfer;
  int done0, done1;
  int m_x0, m_x1, m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = -1; m_last = 1; m_cnt = 0; m_blocked = 1; last_xfer = -1;
    m_x0 = 0; m_x1 = 0; m_wait = 0;
  endtask

  task automatic cycle(input logic [1:0] req, input logic [1:0] lock,
                       input logic [13:0] a0, input logic [13:0] a1, input logic rdy);
    logic [1:0] g1h;
    logic [13:0] a;
    int oth;
    rq_req = req; rq_lock = lock; rq_addr0 = a0; rq_addr1 = a1; gray_ready = rdy;
    g1h = (m_hold < 0) ? 2'b00 : ((m_hold == 1) ? 2'b10 : 2'b01);
    gnt_q.push_back('{cyc, g1h});
    last_xfer = -1;
    if ((req & ~g1h) != 2'b00) m_wait++;
    if (m_hold >= 0 && req[m_hold]) begin
      a = (m_hold == 1) ? a1 : a0;
      rsp_q.push_back('{cyc + 1, m_hold, a});
      last_xfer = m_hold;
      if (m_hold == 1) begin done1++; m_x1++; end else begin done0++; m_x0++; end
    end
    if (m_blocked) begin
      if (rdy) m_blocked = 0;
    end else if (m_hold < 0) begin
      if (!rdy) m_blocked = 1;
      else if (req != 2'b00) begin
        m_hold = (req == 2'b11) ? (1 - m_last) : (req[1] ? 1 : 0);
        m_last = m_hold;
        m_cnt  = 0;
      end
    end else begin
      oth = 1 - m_hold;
      if (req[m_hold] && m_cnt < MAXB) m_cnt++;
      if (!rdy) begin
        m_hold = -1; m_blocked = 1;
      end else if ((!req[m_hold] && !lock[m_hold]) || (req[oth] && m_cnt >= MAXB)) begin
        m_hold = -1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset = 1'b0;
    #1;
    chk("rst_gnt", {30'd0, rq_gnt}, 32'd0);
    chk("rst_gray_req", {31'd0, gray_req}, 32'd0);
    chk("rst_rvalid", {30'd0, rq_rvalid}, 32'd0);
`ifdef GRAY_ARB_STAT_EN
    chk("rst_stat_xfer0", {16'd0, stat_xfer0}, 32'd0);
    chk("rst_stat_xfer1", {16'd0, stat_xfer1}, 32'd0);
    chk("rst_stat_wait", {16'd0, stat_wait}, 32'd0);
`endif
    gnt_q.delete();
    rsp_q.delete();
    model_reset();
    rq_req = 2'b00; rq_lock = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1;
  endtask

  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (gnt_q.size() > 0 && gnt_q[0].due == cyc) begin
        gnt_t e;
        e = gnt_q.pop_front();
        chk("gnt", {30'd0, rq_gnt}, {30'd0, e.g});
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rvalid", {30'd0, rq_rvalid}, (r.who == 1) ? 32'd2 : 32'd1);
        chk("rdata", {24'd0, rq_rdata}, {24'd0, pix(r.addr)});
        chk("gray_req", {31'd0, gray_req}, 32'd1);
        chk("gray_addr", {18'd0, gray_addr}, {18'd0, r.addr});
      end else begin
        chk("rvalid_idle", {30'd0, rq_rvalid}, 32'd0);
        chk("gray_req_idle", {31'd0, gray_req}, 32'd0);
      end
    end
  end

  logic [13:0] alist [4];

  initial begin
    int k, guard, down, rem0, rem1, prev;
    bit dropped;
    logic [1:0] r;
    logic rdy;
    alist[0] = 14'd0; alist[1] = 14'd1; alist[2] = 14'd2; alist[3] = 14'd128;
    reset = 1'b0; rq_req = 0; rq_lock = 0; rq_addr0 = 0; rq_addr1 = 0; gray_ready = 0;
    model_reset();
    done0 = 0; done1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("por_gnt", {30'd0, rq_gnt}, 32'd0);
    chk("por_rvalid", {30'd0, rq_rvalid}, 32'd0);
    chk("por_gray_addr", {18'd0, gray_addr}, 32'd0);
    reset = 1'b1;
    mon_en = 1;

    // memory not ready, then ready
    repeat (5) cycle(2'b01, 2'b00, 14'd5, 14'd0, 1'b0);
    repeat (4) cycle(2'b01, 2'b00, 14'd5, 14'd0, 1'b1);
    repeat (3) cycle(2'b00, 2'b00, 14'd0, 14'd0, 1'b1);

    // locked burst over fixed addresses
    k = 0; guard = 0;
    while (k < 4 && guard < 20) begin
      cycle(2'b01, 2'b01, alist[k], 14'd0, 1'b1);
      if (last_xfer == 0) k++;
      guard++;
    end
    chk("t2_done", k, 4);
    repeat (3) cycle(2'b00, 2'b00, 14'd0, 14'd0, 1'b1);

    // alternating single transfers from a fresh reset
    do_reset();
    cycle(2'b00, 2'b00, 14'd0, 14'd0, 1'b1);
    rem0 = 2; rem1 = 2; guard = 0; prev = -1;
    while ((rem0 > 0 || rem1 > 0) && guard < 40) begin
      r[0] = (rem0 > 0) && (prev != 0);
      r[1] = (rem1 > 0) && (prev != 1);
      cycle(r, 2'b00, 14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 1'b1);
      prev = last_xfer;
      if (last_xfer == 0) rem0--;
      if (last_xfer == 1) rem1--;
      guard++;
    end
    chk("t3_done", rem0 + rem1, 0);
    repeat (2) cycle(2'b00, 2'b00, 14'd0, 14'd0, 1'b1);

    // starvation cap on a locked burst
    done0 = 0; done1 = 0; guard = 0;
    while ((done0 < 20 || done1 < 3) && guard < 80) begin
      r[0] = (done0 < 20);
      r[1] = (guard >= 3) && (done1 < 3);
      cycle(r, 2'b01, 14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 1'b1);
      guard++;
    end
    chk("t4_done", done0 + done1, 23);
    repeat (3) cycle(2'b00, 2'b00, 14'd0, 14'd0, 1'b1);

    // memory drops on the 4th locked transfer
    done0 = 0; guard = 0; down = 0; dropped = 0;
    while (done0 < 6 && guard < 40) begin
      if (m_hold == 0 && done0 == 3 && !dropped) begin rdy = 0; dropped = 1; down = 3; end
      else if (down > 0) begin rdy = 0; down--; end
      else rdy = 1;
      cycle(2'b01, 2'b01, 14'($urandom_range(0, 16383)), 14'd0, rdy);
      guard++;
    end
    chk("t5_done", done0, 6);

    // reset with a read in flight
    guard = 0;
    while (last_xfer != 0 && guard < 10) begin
      cycle(2'b01, 2'b01, 14'($urandom_range(0, 16383)), 14'd0, 1'b1);
      guard++;
    end
    chk("t6_pending", {30'd0, rq_rvalid}, 32'd1);
    do_reset();

    // random traffic
    repeat (400) begin
      cycle(2'($urandom), 2'($urandom), 14'($urandom_range(0, 16383)),
            14'($urandom_range(0, 16383)), ($urandom_range(0, 9) != 0));
    end
    repeat (3) cycle(2'b00, 2'b00, 14'd0, 14'd0, 1'b1);
    chk("rsp_q_empty", rsp_q.size(), 0);
`ifdef GRAY_ARB_STAT_EN
    chk("stat_xfer0", {16'd0, stat_xfer0}, m_x0);
    chk("stat_xfer1", {16'd0, stat_xfer1}, m_x1);
    chk("stat_wait", {16'd0, stat_wait}, m_wait);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
